// File: rtl/pu_tag_req_arb.sv
// ============================================================================
// Module   : pu_tag_req_arb
// Purpose  : Round-robin arbiter collecting tag lookup requests from NUM_PU
//            processing units and issuing one key at a time to the tag lookup
//            engine. Issues are spaced ISSUE_GAP cycles apart and the number
//            of lookups in flight is bounded by a credit counter that the
//            engine replenishes through tag_lookup_status_valid.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            req_valid / req_key      - per-PU request and key (slice i)
//            req_ack                  - one-hot grant pulse (combinational)
//            tag_lookup_status_valid  - credit return from the engine
//            tag_key_valid/key/pid    - registered issue to the engine
//            credits                  - credits currently available
//            credit_err               - sticky: return received at full credits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_tag_req_arb #(
  parameter int NUM_PU          = 4,
  parameter int PU_ID_NBITS     = 2,
  parameter int TAG_KEY_NBITS   = 8,
  parameter int ISSUE_GAP       = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PU-1:0]                      req_valid,
  input  logic [NUM_PU*TAG_KEY_NBITS-1:0]        req_key,
  output logic [NUM_PU-1:0]                      req_ack,
  input  logic                                   tag_lookup_status_valid,
  output logic                                   tag_key_valid,
  output logic [TAG_KEY_NBITS-1:0]               tag_key,
  output logic [PU_ID_NBITS-1:0]                 tag_pid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   credits,
  output logic                                   credit_err
);

  localparam int GAP_W  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  localparam logic [GAP_W-1:0]  c_GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
  localparam logic [CRED_W-1:0] c_CRED_MAX   = CRED_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  c_PTR_RESET  = PTR_W'(NUM_PU - 1);

  logic [GAP_W-1:0]         r_gap_cnt;
  logic [CRED_W-1:0]        r_credits;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic                     r_key_valid;
  logic [TAG_KEY_NBITS-1:0] r_key;
  logic [PU_ID_NBITS-1:0]   r_pid;
  logic                     r_credit_err;

  logic                     w_found;
  logic [PTR_W-1:0]         w_gnt_idx;
  logic                     w_issue_ok;
  logic [TAG_KEY_NBITS-1:0] w_gnt_key;

  // Round-robin search: start one past the last granted PU and wrap, so the
  // last winner has the lowest priority on the next arbitration.
  always_comb begin
    int idx;
    idx       = 0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NUM_PU; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_PU;
      if (!w_found && req_valid[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign w_issue_ok = (r_gap_cnt == '0) && (r_credits != '0) && w_found;
  assign w_gnt_key  = req_key[w_gnt_idx*TAG_KEY_NBITS +: TAG_KEY_NBITS];

  // The registers already sit at reset values while rst is high, which would
  // otherwise present a grant; gating keeps the ack quiet during reset.
  assign req_ack = (w_issue_ok && !rst) ? (NUM_PU'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt   <= '0;
      r_rr_ptr    <= c_PTR_RESET;
      r_key_valid <= 1'b0;
      r_key       <= '0;
      r_pid       <= '0;
    end else if (w_issue_ok) begin
      r_gap_cnt   <= c_GAP_RELOAD;
      r_rr_ptr    <= w_gnt_idx;
      r_key_valid <= 1'b1;
      r_key       <= w_gnt_key;
      r_pid       <= PU_ID_NBITS'(w_gnt_idx);
    end else begin
      r_key_valid <= 1'b0;
      if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // A grant consumes a credit, a status return gives one back; both in the
  // same cycle cancel. A return with no credit outstanding is an engine
  // protocol error: the count saturates and the error flag latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits    <= c_CRED_MAX;
      r_credit_err <= 1'b0;
    end else begin
      if (w_issue_ok && !tag_lookup_status_valid) begin
        r_credits <= r_credits - 1'b1;
      end else if (!w_issue_ok && tag_lookup_status_valid) begin
        if (r_credits == c_CRED_MAX) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credits <= r_credits + 1'b1;
        end
      end
    end
  end

  assign tag_key_valid = r_key_valid;
  assign tag_key       = r_key;
  assign tag_pid       = r_pid;
  assign credits       = r_credits;
  assign credit_err    = r_credit_err;

endmodule

`default_nettype wire

// File: doc/pu_tag_req_arb.md
# pu_tag_req_arb

Round-robin request arbiter directly upstream of the tag lookup engine. It collects tag lookup requests from NUM_PU processing units and issues one key at a time on the engine's `tag_key_valid`/`tag_key`/`tag_pid` input. Issues are spaced to match the engine's 8-read value scan. In-flight lookups are bounded by a credit counter that is returned on `tag_lookup_status_valid`.

## Interface
- NUM_PU, default 4: number of requesting PUs; must be ≤ 2^`PU_ID_NBITS`.
- PU_ID_NBITS, default `PU_ID_NBITS`: width of `tag_pid`.
- TAG_KEY_NBITS, default `TAG_KEY_NBITS`: key width.
- ISSUE_GAP, default 8: minimum number of cycles between two issues; must be ≥1.
- MAX_OUTSTANDING, default 2: maximum number of issued lookups without a status return.

Ports:
- clk  in  1  clock.
- `RESET_SIG`  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_PU  per-PU request pending; held until acked.
- req_key  in  NUM_PU*TAG_KEY_NBITS  per-PU key; slice i is [i*TAG_KEY_NBITS +: TAG_KEY_NBITS].
- req_ack  out  NUM_PU  one-cycle, one-hot grant pulse (combinational).
- tag_lookup_status_valid  in  1  credit return from the lookup engine.
- tag_key_valid  out  1  issue strobe to the lookup engine (registered).
- tag_key  out  TAG_KEY_NBITS  issued key (registered).
- tag_pid  out  PU_ID_NBITS  index of the granted PU, zero-extended (registered).
- credits  out  $clog2(MAX_OUTSTANDING+1)  credits currently available.
- credit_err  out  1  sticky; set by a status return that arrives while credits==MAX_OUTSTANDING.

## Operation
- State registers:
  - gap_cnt: $clog2(ISSUE_GAP+1) bits.
  - credits.
  - rr_ptr: index of the last granted PU.
  - output registers.
- Issue enable: `issue_ok = (gap_cnt==0) && (credits!=0) && |req_valid`.
- Grant when issue_ok: g is the first index with req_valid set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_PU, wrapping past NUM_PU-1 to 0. req_ack[g] is high in the same cycle.
- On a grant edge:
  - rr_ptr←g.
  - gap_cnt←ISSUE_GAP-1.
  - tag_key←req_key slice g; tag_pid←g; tag_key_valid←1.
- On a non-grant edge: tag_key_valid←0. tag_key and tag_pid hold their values.
- gap_cnt decrements by 1 each cycle while nonzero.
- credits update:
  - −1 on a grant.
  - +1 on tag_lookup_status_valid.
  - Both in the same cycle: unchanged.
  - Status return at credits==MAX_OUTSTANDING with no grant: credits stay at MAX and credit_err←1.
- A PU must keep req_valid and its key stable until it sees req_ack. Deasserting req_valid before the ack withdraws the request without error.
- No request is lost or duplicated. Each req_ack pulse produces exactly one tag_key_valid pulse.

## Timing
- Reset values:
  - tag_key_valid=0, tag_key=0, tag_pid=0.
  - credits=MAX_OUTSTANDING, credit_err=0.
  - gap_cnt=0.
  - rr_ptr=NUM_PU-1, so the first grant search starts at PU 0.
- Latency: a grant at cycle T gives req_ack at T and tag_key_valid at T+1.
- Issue spacing:
  - After a grant at T, gap_cnt is ISSUE_GAP-1 at T+1 and reaches 0 at T+ISSUE_GAP. The next grant is possible at T+ISSUE_GAP.
  - With ISSUE_GAP=1, grants can occur back-to-back every cycle.
- A credit returned at cycle T can be used for a grant at T+1 or later, not at T.
- Reset asserted mid-operation:
  - All state returns to reset values asynchronously.
  - Any tag_key_valid pulse not yet sent is dropped.
  - req_ack is forced to 0 while reset is asserted.

## Test plan
- Single request: PU2 raises req_valid with key 0xA5 at cycle 10 → req_ack=0b0100 at cycle 10; at cycle 11 tag_key_valid=1, tag_key=0xA5, tag_pid=2; credits 2→1.
- Fairness: all 4 PUs request continuously, status returned 3 cycles after each issue, ISSUE_GAP=8 → grants in order 0,1,2,3,0 at cycles t, t+8, t+16, t+24, t+32.
- Credit stall: no status returns, PU0 requests continuously → 2 grants 8 cycles apart, then no acks and credits=0. A status pulse at cycle S → next grant at S+1.
- Simultaneous grant and return at credits=1 → credits stays 1. A spurious status pulse at credits=2 → credit_err=1 and stays set, credits stays 2.
- Wrap: rr_ptr=3 with only PU1 and PU3 requesting → PU1 is granted first, then PU3.
- Reset mid-gap: assert reset 3 cycles after a grant → outputs are at reset values immediately. After release, a pending request is granted on the first cycle, with no gap wait.
